// File: rtl/dm_bus_master.sv
// dm_bus_master: MEM-stage load/store initiator. Turns byte/half/word
// accesses into word-aligned request/acknowledge bus transactions, stalls
// the pipeline until completion, extracts and extends load data, and
// reports misaligned accesses and bus timeouts.

`ifndef WIDTH_DMSIZESEL
`define WIDTH_DMSIZESEL 2
`endif
`ifndef WIDTH_DMEXTSEL
`define WIDTH_DMEXTSEL 1
`endif

module dm_bus_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        MemRead,
  input  logic                        MemWrite,
  input  logic [`WIDTH_DMSIZESEL-1:0] DMSizeSel,
  input  logic [`WIDTH_DMEXTSEL-1:0]  DMExtSel,
  input  logic [31:0]                 Addr,
  input  logic [31:0]                 WD,
  output logic                        Stall,
  output logic [31:0]                 RD,
  output logic                        RDValid,
  output logic                        AlignErr,
  output logic                        BusErr,
  output logic [31:0]                 BadVAddr,
  output logic                        BusReq,
  output logic                        BusWE,
  output logic [31:0]                 BusAddr,
  output logic [3:0]                  BusBE,
  output logic [31:0]                 BusWData,
  input  logic                        BusAck,
  input  logic [31:0]                 BusRData
);

  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state, next_state;

  logic [CNT_W-1:0] cnt;
  logic             start, align_fault, ack_hit, timeout_hit;

  logic             req, is_half, is_byte, misaligned;
  logic [3:0]       be_next;
  logic [31:0]      wdata_next;

  logic             we_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [1:0]       off_q;
  logic [31:0]      addr_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic             in_req;

  // Pick the addressed field out of a read word and sign- or zero-extend it.
  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [1:0]  size,
                                          input logic [1:0]  off,
                                          input logic        uns);
    logic [15:0] half_v;
    logic [7:0]  lane_v;
    logic [31:0] res;
    half_v = off[1] ? word[31:16] : word[15:0];
    case (off)
      2'd0:    lane_v = word[7:0];
      2'd1:    lane_v = word[15:8];
      2'd2:    lane_v = word[23:16];
      default: lane_v = word[31:24];
    endcase
    case (size)
      SZ_HALF: res = {{16{half_v[15] & ~uns}}, half_v};
      SZ_BYTE: res = {{24{lane_v[7] & ~uns}}, lane_v};
      default: res = word;
    endcase
    return res;
  endfunction

  assign req     = MemRead | MemWrite;
  assign is_half = (DMSizeSel == SZ_HALF);
  assign is_byte = (DMSizeSel == SZ_BYTE);

  // Classify the incoming access and build its byte enables and write lanes.
  always_comb begin
    misaligned = 1'b0;
    be_next    = 4'b1111;
    wdata_next = WD;
    if (is_half) begin
      misaligned = Addr[0];
      be_next    = Addr[1] ? 4'b1100 : 4'b0011;
      wdata_next = {2{WD[15:0]}};
    end else if (is_byte) begin
      be_next    = 4'b0001 << Addr[1:0];
      wdata_next = {4{WD[7:0]}};
    end else begin
      misaligned = (Addr[1:0] != 2'b00);
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode plus the combinational Stall and BusReq.
  always_comb begin
    next_state  = state;
    start       = 1'b0;
    align_fault = 1'b0;
    ack_hit     = 1'b0;
    timeout_hit = 1'b0;
    Stall       = 1'b0;
    BusReq      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (misaligned) begin
            align_fault = 1'b1;
          end else begin
            start      = 1'b1;
            Stall      = Reset;
            next_state = REQ;
          end
        end
      end
      REQ: begin
        BusReq = 1'b1;
        Stall  = 1'b1;
        if (BusAck) begin
          ack_hit    = 1'b1;
          next_state = DONE;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          next_state  = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Timeout counter: restarts on each new transaction, counts REQ cycles.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)              cnt <= '0;
    else if (start)          cnt <= '0;
    else if (state == REQ)   cnt <= cnt + 1'b1;
  end

  // Transaction latches, load result, error pulses and fault address.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      off_q    <= 2'b00;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      RD       <= '0;
      RDValid  <= 1'b0;
      AlignErr <= 1'b0;
      BusErr   <= 1'b0;
      BadVAddr <= '0;
    end else begin
      RDValid  <= 1'b0;
      AlignErr <= 1'b0;
      BusErr   <= 1'b0;
      if (align_fault) begin
        AlignErr <= 1'b1;
        BadVAddr <= Addr;
      end
      if (start) begin
        we_q    <= MemWrite;
        size_q  <= DMSizeSel;
        uns_q   <= DMExtSel[0];
        off_q   <= Addr[1:0];
        addr_q  <= {Addr[31:2], 2'b00};
        be_q    <= be_next;
        wdata_q <= MemWrite ? wdata_next : 32'h0;
      end
      if (ack_hit && !we_q) begin
        RD      <= extract(BusRData, size_q, off_q, uns_q);
        RDValid <= 1'b1;
      end
      if (timeout_hit) begin
        BusErr <= 1'b1;
        if (!we_q) RD <= '0;
      end
    end
  end

  assign in_req   = (state == REQ);
  assign BusWE    = in_req & we_q;
  assign BusAddr  = in_req ? addr_q  : 32'h0;
  assign BusBE    = in_req ? be_q    : 4'h0;
  assign BusWData = in_req ? wdata_q : 32'h0;

endmodule

// File: tb/tb_dm_bus_master.sv
// tb_dm_bus_master: table vectors, hand sequences and random transactions
// for dm_bus_master, checked against a transaction-level reference model.

module tb_dm_bus_master;

  localparam int TMO = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        MemRead, MemWrite;
  logic [1:0]  DMSizeSel;
  logic [0:0]  DMExtSel;
  logic [31:0] Addr, WD;
  logic        Stall, RDValid, AlignErr, BusErr, BusReq, BusWE;
  logic [31:0] RD, BadVAddr, BusAddr, BusWData, BusRData;
  logic [3:0]  BusBE;
  logic        BusAck;

  int nCompared = 0;
  int nMismatched = 0;
  logic [31:0] rdModel = 32'h0;
  logic [31:0] badModel = 32'h0;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        ext;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [7:0]  ackDelay;
    logic [31:0] rdata;
    logic        expAlign;
    logic [3:0]  expBE;
    logic [31:0] expWData;
    logic [31:0] expRD;
  } vec_t;

  vec_t tbl [10];

  dm_bus_master #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .DMSizeSel(DMSizeSel), .DMExtSel(DMExtSel), .Addr(Addr), .WD(WD),
    .Stall(Stall), .RD(RD), .RDValid(RDValid), .AlignErr(AlignErr),
    .BusErr(BusErr), .BadVAddr(BadVAddr), .BusReq(BusReq), .BusWE(BusWE),
    .BusAddr(BusAddr), .BusBE(BusBE), .BusWData(BusWData),
    .BusAck(BusAck), .BusRData(BusRData)
  );

  always #5 Clk = ~Clk;

  function automatic vec_t mkVec(logic rd, logic wr, logic [1:0] sz, logic ext,
                                 logic [31:0] addr, logic [31:0] wd, logic [7:0] ackDelay,
                                 logic [31:0] rdata, logic expAlign, logic [3:0] expBE,
                                 logic [31:0] expWData, logic [31:0] expRD);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sz = sz; v.ext = ext; v.addr = addr; v.wd = wd;
    v.ackDelay = ackDelay; v.rdata = rdata; v.expAlign = expAlign;
    v.expBE = expBE; v.expWData = expWData; v.expRD = expRD;
    return v;
  endfunction

  function automatic int ackOf(vec_t v);
    return (v.ackDelay == 8'hFF) ? -1 : int'(v.ackDelay);
  endfunction

  // Reference model: derives enables, write lanes and load result from access size arithmetic.
  function automatic vec_t modelTxn(vec_t v, logic [31:0] rdNow);
    int bytes, off, lane, ad;
    logic [63:0] mask, fld, wdat;
    bytes = (v.sz == 2'b01) ? 2 : (v.sz == 2'b10) ? 1 : 4;
    off   = int'(v.addr[1:0]);
    lane  = off - (off % bytes);
    mask  = (64'd1 << (8 * bytes)) - 64'd1;
    v.expAlign = (off % bytes) != 0;
    v.expBE = 4'(((1 << bytes) - 1) << lane);
    wdat = 64'h0;
    if (v.wr)
      for (int i = 0; i < 4 / bytes; i++) wdat = wdat | ((64'(v.wd) & mask) << (8 * bytes * i));
    v.expWData = wdat[31:0];
    fld = (64'(v.rdata) >> (8 * lane)) & mask;
    if (!v.ext && fld[8 * bytes - 1]) fld = fld | ~mask;
    ad = ackOf(v);
    if (v.wr || v.expAlign)        v.expRD = rdNow;
    else if (ad >= 0 && ad < TMO)  v.expRD = fld[31:0];
    else                           v.expRD = 32'h0;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one access from the MEM stage and follow it cycle by cycle.
  task automatic applyStimulus(input vec_t v);
    int ad, reqCycles;
    bit acked, done;
    ad = ackOf(v);
    acked = (ad >= 0 && ad < TMO);
    @(posedge Clk); #1;
    MemRead = v.rd; MemWrite = v.wr; DMSizeSel = v.sz; DMExtSel = v.ext;
    Addr = v.addr; WD = v.wd; BusAck = 1'b0; BusRData = $urandom;
    @(negedge Clk);
    checkOutput("idleStall", 32'(Stall), 32'(!v.expAlign));
    checkOutput("idleBusReq", 32'(BusReq), 32'h0);
    checkOutput("idleAlignErr", 32'(AlignErr), 32'h0);
    if (v.expAlign) begin
      @(posedge Clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0;
      @(negedge Clk);
      badModel = v.addr;
      checkOutput("alignErr", 32'(AlignErr), 32'h1);
      checkOutput("badVAddr", BadVAddr, badModel);
      checkOutput("alignBusReq", 32'(BusReq), 32'h0);
      checkOutput("alignRDValid", 32'(RDValid), 32'h0);
      checkOutput("alignRD", RD, v.expRD);
      rdModel = v.expRD;
      return;
    end
    reqCycles = 0;
    done = 0;
    while (!done) begin
      @(posedge Clk); #1;
      if (reqCycles == ad) begin BusAck = 1'b1; BusRData = v.rdata; end
      else begin BusAck = 1'b0; BusRData = $urandom; end
      @(negedge Clk);
      checkOutput("reqBusReq", 32'(BusReq), 32'h1);
      checkOutput("reqStall", 32'(Stall), 32'h1);
      checkOutput("reqBusWE", 32'(BusWE), 32'(v.wr));
      checkOutput("reqBusAddr", BusAddr, v.addr & 32'hFFFF_FFFC);
      checkOutput("reqBusBE", 32'(BusBE), 32'(v.expBE));
      checkOutput("reqBusWData", BusWData, v.expWData);
      reqCycles++;
      if ((reqCycles - 1) == ad || reqCycles >= TMO) done = 1;
    end
    @(posedge Clk); #1;
    BusAck = $urandom_range(0, 1); BusRData = $urandom;
    @(negedge Clk);
    checkOutput("doneStall", 32'(Stall), 32'h0);
    checkOutput("doneBusReq", 32'(BusReq), 32'h0);
    checkOutput("doneRDValid", 32'(RDValid), 32'(acked && !v.wr));
    checkOutput("doneBusErr", 32'(BusErr), 32'(!acked));
    checkOutput("doneRD", RD, v.expRD);
    checkOutput("doneBadVAddr", BadVAddr, badModel);
    @(posedge Clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0; BusAck = 1'b1;
    @(negedge Clk);
    checkOutput("afterBusReq", 32'(BusReq), 32'h0);
    checkOutput("afterStall", 32'(Stall), 32'h0);
    checkOutput("afterRDValid", 32'(RDValid), 32'h0);
    checkOutput("afterRD", RD, v.expRD);
    rdModel = v.expRD;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Stall"}, 32'(Stall), 32'h0);
    checkOutput({tag, "BusReq"}, 32'(BusReq), 32'h0);
    checkOutput({tag, "RD"}, RD, 32'h0);
    checkOutput({tag, "Pulses"}, {29'h0, RDValid, AlignErr, BusErr}, 32'h0);
    checkOutput({tag, "BadVAddr"}, BadVAddr, 32'h0);
    checkOutput({tag, "BusWE"}, 32'(BusWE), 32'h0);
    checkOutput({tag, "BusAddr"}, BusAddr, 32'h0);
    checkOutput({tag, "BusBE"}, 32'(BusBE), 32'h0);
    checkOutput({tag, "BusWData"}, BusWData, 32'h0);
  endtask

  initial begin
    vec_t v;
    Reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; DMSizeSel = 2'b00; DMExtSel = 1'b0;
    Addr = 32'h0; WD = 32'h0; BusAck = 1'b0; BusRData = 32'h0;

    tbl[0] = mkVec(1, 0, 2'b00, 0, 32'h100, 32'h0,        8'd0,  32'hDEADBEEF, 0, 4'b1111, 32'h0,        32'hDEADBEEF);
    tbl[1] = mkVec(0, 1, 2'b10, 0, 32'h203, 32'h000000A5, 8'd3,  32'h0,        0, 4'b1000, 32'hA5A5A5A5, 32'hDEADBEEF);
    tbl[2] = mkVec(1, 0, 2'b01, 0, 32'h102, 32'h0,        8'd1,  32'h80011234, 0, 4'b1100, 32'h0,        32'hFFFF8001);
    tbl[3] = mkVec(1, 0, 2'b10, 1, 32'h101, 32'h0,        8'd0,  32'h80011234, 0, 4'b0010, 32'h0,        32'h00000012);
    tbl[4] = mkVec(1, 0, 2'b00, 0, 32'h106, 32'h0,        8'd0,  32'h0,        1, 4'b0000, 32'h0,        32'h00000012);
    tbl[5] = mkVec(0, 1, 2'b01, 0, 32'h400, 32'h1234ABCD, 8'd1,  32'h0,        0, 4'b0011, 32'hABCDABCD, 32'h00000012);
    tbl[6] = mkVec(0, 1, 2'b01, 0, 32'h401, 32'h1234ABCD, 8'd0,  32'h0,        1, 4'b0000, 32'h0,        32'h00000012);
    tbl[7] = mkVec(1, 0, 2'b11, 0, 32'h010, 32'h0,        8'd2,  32'h0F0F0F0F, 0, 4'b1111, 32'h0,        32'h0F0F0F0F);
    tbl[8] = mkVec(1, 0, 2'b10, 0, 32'h103, 32'h0,        8'd0,  32'h80FFFFFF, 0, 4'b1000, 32'h0,        32'hFFFFFF80);
    tbl[9] = mkVec(1, 1, 2'b00, 0, 32'h020, 32'hCAFEF00D, 8'd2,  32'h12345678, 0, 4'b1111, 32'hCAFEF00D, 32'hFFFFFF80);

    #3;
    checkAllZero("rst");
    @(negedge Clk); @(negedge Clk);
    Reset = 1'b1;

    for (int i = 0; i < 10; i++) applyStimulus(tbl[i]);

    // Timeout: read with no acknowledge at all.
    v = mkVec(1, 0, 2'b00, 0, 32'h300, 32'h0, 8'hFF, 32'h0, 0, 4'b1111, 32'h0, 32'h0);
    applyStimulus(v);

    // Reset while a transaction is waiting on the bus.
    @(posedge Clk); #1;
    MemRead = 1'b1; MemWrite = 1'b0; DMSizeSel = 2'b00; Addr = 32'h500; BusAck = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    checkOutput("preRstBusReq", 32'(BusReq), 32'h1);
    #2 Reset = 1'b0;
    #1;
    checkAllZero("midRst");
    @(negedge Clk);
    MemRead = 1'b0;
    Reset = 1'b1;
    rdModel = 32'h0;
    badModel = 32'h0;
    BusAck = 1'b1; BusRData = 32'h55AA55AA;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checkOutput("lateAckRDValid", 32'(RDValid), 32'h0);
      checkOutput("lateAckBusReq", 32'(BusReq), 32'h0);
      checkOutput("lateAckRD", RD, 32'h0);
    end
    v = mkVec(1, 0, 2'b01, 1, 32'h502, 32'h0, 8'd1, 32'h9876ABCD, 0, 4'b1100, 32'h0, 32'h00009876);
    applyStimulus(v);

    // Randomized accesses against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [2:0] r;
      v.wr = 1'($urandom_range(0, 1));
      v.rd = v.wr ? 1'($urandom_range(0, 1)) : 1'b1;
      v.sz = 2'($urandom_range(0, 3));
      v.ext = 1'($urandom_range(0, 1));
      v.addr = $urandom;
      v.wd = $urandom;
      v.rdata = $urandom;
      r = 3'($urandom_range(0, 4));
      v.ackDelay = (r == 3'd4) ? 8'hFF : 8'(r);
      v = modelTxn(v, rdModel);
      applyStimulus(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/dm_bus_master.md
Name: dm_bus_master

Overview:
- MEM-stage load/store initiator; replaces the single-cycle, zero-latency data-memory path with a word-granular request/acknowledge bus toward an external data memory or responder.
- Converts byte, halfword and word accesses into word-aligned bus transactions with byte enables and lane-replicated write data.
- Extracts and sign- or zero-extends load data.
- Stalls the pipeline until the transaction completes, and flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in REQ without BusAck before the transaction is aborted with BusErr. Legal range 1..65535.
- CNT_W, 16: width of the timeout counter.

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous reset, active-low
- MemRead  in  1  load request from MEM stage
- MemWrite  in  1  store request from MEM stage
- DMSizeSel  in  `WIDTH_DMSIZESEL  access size: WORD=2'b00, HALF=2'b01, BYTE=2'b10; 2'b11 is treated as WORD
- DMExtSel  in  `WIDTH_DMEXTSEL  load extension: SIGN=1'b0, UNSIGN=1'b1
- Addr  in  32  byte address
- WD  in  32  store data, right-justified
- Stall  out  1  holds IF/ID/EX/MEM pipeline registers
- RD  out  32  extended load data
- RDValid  out  1  one-cycle pulse when RD is new
- AlignErr  out  1  one-cycle pulse for a misaligned access
- BusErr  out  1  one-cycle pulse for a timeout
- BadVAddr  out  32  address of the last misaligned access
- BusReq  out  1  bus request
- BusWE  out  1  1 = write
- BusAddr  out  32  {Addr[31:2],2'b00}
- BusBE  out  4  byte enables
- BusWData  out  32  lane-replicated write data
- BusAck  in  1  responder completion; sampled only in REQ
- BusRData  in  32  read word; valid in the BusAck cycle

Behaviour:
- Reset (Reset=0, async):
  - state=IDLE; counter cleared.
  - All outputs 0.
  - Any in-flight transaction is dropped; a late BusAck after reset release is ignored because the block is in IDLE.
- Request qualification:
  - Request = MemRead|MemWrite. If both are set, it is a write and MemRead is ignored.
- Misalignment rules:
  - HALF with Addr[0]=1 is misaligned.
  - WORD with Addr[1:0]!=0 is misaligned.
  - In IDLE, a misaligned request: AlignErr=1 next cycle, BadVAddr<=Addr, no bus transaction, Stall=0, RDValid=0.
- FSM:
  - IDLE:
    - Aligned request: Stall=1 combinationally. Latch WE, size, ext, Addr[1:0], BusAddr, BusBE, BusWData. Go to REQ.
  - REQ:
    - BusReq=1; all Bus* outputs held stable; Stall=1; counter increments each cycle.
    - On BusAck: for a read, RD<=extract(BusRData) and RDValid=1 next cycle. Go to DONE.
    - When the counter reaches TIMEOUT_CYCLES-1 without BusAck: BusErr=1 next cycle, RD<=0, go to DONE. If BusAck arrives in the same cycle as the timeout, BusAck wins.
  - DONE:
    - BusReq=0, Stall=0, so the pipeline advances at this edge. Request inputs are ignored. Go to IDLE.
- Latency:
  - Zero-wait responder (BusAck in the first REQ cycle): Stall high for 2 cycles, result in the 3rd.
  - An ack in REQ cycle k gives Stall high for k+1 cycles.
- BusBE:
  - WORD: 4'b1111.
  - HALF: 4'b0011 if Addr[1]=0, else 4'b1100.
  - BYTE: 4'b0001<<Addr[1:0].
  - Reads use the same enables.
- BusWData:
  - WORD: WD.
  - HALF: {2{WD[15:0]}}.
  - BYTE: {4{WD[7:0]}}.
  - Reads: 0.
- Read extraction, using latched offset and size:
  - HALF selects BusRData[15:0] or [31:16] by Addr[1].
  - BYTE selects lane Addr[1:0].
  - SIGN replicates the MSB of the selected field; UNSIGN zero-fills.
- Holding rules:
  - RD holds its value until the next completed read.
  - BadVAddr holds until the next misaligned access.
- A write never updates RD.

Test Plan:
- Word load, zero-wait: Addr=0x100, BusAck in the first REQ cycle, BusRData=0xDEADBEEF -> BusAddr=0x100, BE=1111, Stall high 2 cycles, then RDValid=1 and RD=0xDEADBEEF.
- Byte store with 3 wait states: Addr=0x203, WD=0x000000A5 -> BusWE=1, BusAddr=0x200, BE=1000, BusWData=0xA5A5A5A5 held for 4 cycles, Stall high 5 cycles, RD unchanged.
- Sign/zero extend:
  - Half load at Addr=0x102, BusRData=0x8001_1234, SIGN -> RD=0xFFFF8001.
  - Byte load at Addr=0x101, UNSIGN -> RD=0x00000012.
- Misaligned: word load at Addr=0x106 -> AlignErr pulse, BadVAddr=0x106, BusReq never asserted, Stall=0.
- Timeout: TIMEOUT_CYCLES=4, BusAck never asserted -> BusReq high exactly 4 cycles, then BusErr pulse, RD=0, Stall releases in the next (DONE) cycle.
- Reset mid-REQ: Reset=0 while BusReq=1 -> all outputs 0 immediately. After Reset returns high, an ack-less idle bus gives no RDValid; a new aligned request completes normally.
